// File: rtl/pb_debouncer_pkg.sv
// Shared types and default constants for the pushbutton debouncer.
package pb_debouncer_pkg;

  localparam int unsigned PB_SYNC_STAGES_DEF   = 2;
  localparam int unsigned PB_STABLE_CYCLES_DEF = 16;

  // Debounce FSM: two settled levels, each with a qualification state
  // that is entered when the synchronized input starts to disagree.
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    QUAL_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    QUAL_LOW  = 2'd3
  } pb_state_e;

endpackage : pb_debouncer_pkg

// File: rtl/pb_debouncer_if.sv
// Pushbutton pin in, debounced level and filter status out.
interface pb_debouncer_if;

  logic pb_raw;
  logic pb_clean;
  logic filtering;

  modport master (
    output pb_raw,
    input  pb_clean,
    input  filtering
  );

  modport slave (
    input  pb_raw,
    output pb_clean,
    output filtering
  );

endinterface : pb_debouncer_if

// File: rtl/pb_sync.sv
// Multi-flop synchronizer for one asynchronous bit; every stage resets to RST_VAL.
module pb_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the input through the flop chain; reset forces the idle level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule : pb_sync

// File: rtl/pb_debouncer.sv
// Pushbutton debouncer: synchronizer followed by a four-state qualification FSM.
// A new level is accepted only after STABLE_CYCLES consecutive agreeing samples.
// Build option: PB_DEBOUNCER_ACTIVE_LOW_EN -- pin is active-low (released = 1);
// it is inverted ahead of the synchronizer so pb_clean stays active-high.
module pb_debouncer
  import pb_debouncer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = PB_SYNC_STAGES_DEF,
  parameter int unsigned STABLE_CYCLES = PB_STABLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES) + 1
) (
  input  logic           clk,
  input  logic           reset,
  pb_debouncer_if.slave  pb_if
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic raw_lvl;

`ifdef PB_DEBOUNCER_ACTIVE_LOW_EN
  // Released pin reads 1; after inversion that idle level is 0, which is
  // what the synchronizer holds in reset.
  localparam logic SYNC_RST = 1'b0;
  assign raw_lvl = ~pb_if.pb_raw;
`else
  localparam logic SYNC_RST = 1'b0;
  assign raw_lvl = pb_if.pb_raw;
`endif

  logic      sync_q;
  pb_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic      pb_clean_q, pb_clean_d;
  logic      filtering_q, filtering_d;

  pb_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (SYNC_RST)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (raw_lvl),
    .q_o   (sync_q)
  );

  // State, counter and registered outputs; reset drops any pending change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE_LOW;
      cnt_q       <= '0;
      pb_clean_q  <= 1'b0;
      filtering_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pb_clean_q  <= pb_clean_d;
      filtering_q <= filtering_d;
    end
  end

  // Next state, counter, and output decode of the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE_LOW: begin
        if (sync_q) begin
          state_d = QUAL_HIGH;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      QUAL_HIGH: begin
        if (!sync_q) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!sync_q) begin
          state_d = QUAL_LOW;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      QUAL_LOW: begin
        if (sync_q) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase

    pb_clean_d  = (state_d == IDLE_HIGH) || (state_d == QUAL_LOW);
    filtering_d = (state_d == QUAL_HIGH) || (state_d == QUAL_LOW);
  end

  assign pb_if.pb_clean  = pb_clean_q;
  assign pb_if.filtering = filtering_q;

endmodule : pb_debouncer

// File: tb/tb_pb_debouncer.sv
// Directed bench for pb_debouncer with SYNC_STAGES=2, STABLE_CYCLES=4.
// Stimulus is expressed as pressed/released; the pin level follows the build polarity.
module tb_pb_debouncer;

`ifdef PB_DEBOUNCER_ACTIVE_LOW_EN
  localparam bit ACT_LOW = 1'b1;
`else
  localparam bit ACT_LOW = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pb_debouncer_if pb_if ();

  pb_debouncer #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pb_if (pb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic press(input bit p);
    pb_if.pb_raw = p ^ ACT_LOW;
  endtask

  // One rising edge, then return to the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    press(1'b0);
    #1;
    chk("rst_clean_async", pb_if.pb_clean, 1'b0);
    chk("rst_filt_async", pb_if.filtering, 1'b0);
    steps(3);
    chk("rst_clean", pb_if.pb_clean, 1'b0);
    chk("rst_filt", pb_if.filtering, 1'b0);
    reset = 1'b0;
    steps(3);
    chk("idle_low_clean", pb_if.pb_clean, 1'b0);
    chk("idle_low_filt", pb_if.filtering, 1'b0);

    // Clean press held 10 cycles.
    press(1'b1);
    steps(2);
    chk("press_e2_filt", pb_if.filtering, 1'b0);
    step();
    chk("press_e3_filt", pb_if.filtering, 1'b1);
    chk("press_e3_clean", pb_if.pb_clean, 1'b0);
    step();
    chk("press_e4_filt", pb_if.filtering, 1'b1);
    step();
    chk("press_e5_filt", pb_if.filtering, 1'b1);
    chk("press_e5_clean", pb_if.pb_clean, 1'b0);
    step();
    chk("press_e6_clean", pb_if.pb_clean, 1'b1);
    chk("press_e6_filt", pb_if.filtering, 1'b0);
    steps(4);
    chk("press_e10_clean", pb_if.pb_clean, 1'b1);

    // One-cycle release glitch while settled high.
    press(1'b0);
    step();
    press(1'b1);
    step();
    chk("glitch_e2_filt", pb_if.filtering, 1'b0);
    step();
    chk("glitch_e3_filt", pb_if.filtering, 1'b1);
    chk("glitch_e3_clean", pb_if.pb_clean, 1'b1);
    step();
    chk("glitch_e4_filt", pb_if.filtering, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("glitch_hold_clean", pb_if.pb_clean, 1'b1);
    end

    // Steady release.
    press(1'b0);
    steps(5);
    chk("release_e5_clean", pb_if.pb_clean, 1'b1);
    chk("release_e5_filt", pb_if.filtering, 1'b1);
    step();
    chk("release_e6_clean", pb_if.pb_clean, 1'b0);
    chk("release_e6_filt", pb_if.filtering, 1'b0);
    steps(3);

    // Bouncy press: high 2, low 1, then steady high.
    press(1'b1);
    steps(2);
    press(1'b0);
    step();
    press(1'b1);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("bounce_no_pulse", pb_if.pb_clean, 1'b0);
    end
    chk("bounce_e5_filt", pb_if.filtering, 1'b1);
    step();
    chk("bounce_e6_clean", pb_if.pb_clean, 1'b1);
    steps(2);

    // Back to released.
    press(1'b0);
    steps(8);
    chk("bounce_rel_clean", pb_if.pb_clean, 1'b0);

    // Reset in the middle of QUAL_HIGH, then full requalification.
    press(1'b1);
    steps(3);
    chk("qual_before_rst_filt", pb_if.filtering, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_qual_filt", pb_if.filtering, 1'b0);
    chk("rst_mid_qual_clean", pb_if.pb_clean, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    steps(2);
    chk("requal_e2_filt", pb_if.filtering, 1'b0);
    step();
    chk("requal_e3_filt", pb_if.filtering, 1'b1);
    steps(2);
    chk("requal_e5_clean", pb_if.pb_clean, 1'b0);
    step();
    chk("requal_e6_clean", pb_if.pb_clean, 1'b1);

    // Reset while settled high clears pb_clean without a clock edge.
    #2;
    reset = 1'b1;
    #1;
    chk("rst_high_clean", pb_if.pb_clean, 1'b0);
    @(negedge clk);
    press(1'b0);
    reset = 1'b0;
    steps(8);
    chk("final_clean", pb_if.pb_clean, 1'b0);
    chk("final_filt", pb_if.filtering, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pb_debouncer

// File: doc/pb_debouncer.md
PB_DEBOUNCER -- requirements
Module: pb_debouncer

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of synchronizer flops (legal 2..4).
REQ-002 Parameter STABLE_CYCLES, default 16, SHALL set the consecutive-sample count needed to accept a level change (legal 2..2^20).
REQ-003 Parameter CNT_W, default clog2(STABLE_CYCLES)+1, SHALL set the qualification counter width.
REQ-004 clk  input  1  SHALL be the rising-edge system clock.
REQ-005 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 pb_raw  input  1  SHALL be the raw asynchronous pushbutton pin.
REQ-007 pb_clean  output  1  SHALL be the debounced level, active-high (pressed = 1); it feeds the downstream one-pulse stage.
REQ-008 filtering  output  1  SHALL be high while a candidate level change is being qualified.

Function
REQ-009 pb_raw (after the optional inversion, REQ-020) SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is sync_q.
REQ-010 FSM states SHALL be IDLE_LOW, QUAL_HIGH, IDLE_HIGH, QUAL_LOW.
REQ-011 IDLE_LOW: sync_q=1 -> QUAL_HIGH with cnt=1; else stay, cnt=0.
REQ-012 QUAL_HIGH: sync_q=0 -> IDLE_LOW, cnt=0; sync_q=1 and cnt=STABLE_CYCLES-1 -> IDLE_HIGH, cnt=0; else cnt+1.
REQ-013 IDLE_HIGH and QUAL_LOW SHALL mirror REQ-011/REQ-012 with sync_q levels inverted, returning to IDLE_LOW on acceptance.
REQ-014 pb_clean SHALL be a registered output: 1 in IDLE_HIGH and QUAL_LOW, 0 in IDLE_LOW and QUAL_HIGH.
REQ-015 filtering SHALL be a registered output: 1 exactly in QUAL_HIGH and QUAL_LOW.
REQ-016 pb_clean SHALL change on the (SYNC_STAGES+STABLE_CYCLES)-th rising edge after the first edge that captures a new, steady pb_raw level.
REQ-017 Any disagreeing sync_q sample during qualification SHALL abort it and restart counting from zero; pb_clean SHALL NOT toggle.
REQ-018 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL NOT wrap.

Reset
REQ-019 While reset is high: all synchronizer stages at the idle level, state IDLE_LOW, cnt=0, pb_clean=0, filtering=0, immediately and independent of clk; reset during qualification SHALL discard the pending change.

Configuration
REQ-020 With PB_DEBOUNCER_ACTIVE_LOW_EN defined, pb_raw SHALL be inverted before the synchronizer, and the synchronizer SHALL reset to 1 at the pin side (idle released = 1); without it, pb_raw is used as-is and resets to 0.
REQ-021 pb_clean polarity SHALL be active-high in both builds.

Structure
REQ-022 Package pb_debouncer_pkg SHALL hold the FSM state typedef and the default SYNC_STAGES/STABLE_CYCLES constants.
REQ-023 The synchronizer SHALL be a sub-module pb_sync, parameterised by stage count and reset value.

Verification (SYNC_STAGES=2, STABLE_CYCLES=4 unless stated)
REQ-024 Reset, then pb_raw 0->1 held 10 cycles -> filtering high edges 3-5, pb_clean=1 from edge 6, filtering 0 from edge 6.
REQ-025 pb_raw high 2 cycles, low 1, then high steady -> no pb_clean pulse from first burst; pb_clean=1 six edges after the final rise.
REQ-026 From IDLE_HIGH, pb_raw 1->0 steady -> pb_clean=0 six edges later; 1-cycle low glitch -> pb_clean stays 1.
REQ-027 Assert reset while filtering=1 in QUAL_HIGH -> pb_clean=0, filtering=0 asynchronously; after release with pb_raw still 1, full 6-edge qualification repeats.
REQ-028 PB_DEBOUNCER_ACTIVE_LOW_EN defined, pb_raw idle 1 -> pb_clean=0 after reset; pb_raw 1->0 held -> pb_clean=1 six edges later.
